// File: rtl/cmp_result_debouncer_pkg.sv
// Shared state encodings and flag decoding for the comparator-result debouncer.
package cmp_result_debouncer_pkg;

    typedef enum logic [1:0] {
        StUnknown = 2'b00,
        StLess    = 2'b01,
        StEqual   = 2'b10,
        StGreater = 2'b11
    } cmp_state_e;

    // Non-one-hot flag sets map to StUnknown, which doubles as the "illegal" marker.
    function automatic cmp_state_e flags_to_state(input logic gt, input logic eq, input logic lt);
        cmp_state_e cls;
        case ({gt, eq, lt})
            3'b100:  cls = StGreater;
            3'b010:  cls = StEqual;
            3'b001:  cls = StLess;
            default: cls = StUnknown;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cmp_result_debouncer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module cmp_result_debouncer_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cmp_result_debouncer.sv
// Qualifies comparator flag samples, debounces them into a stable state and counts outcomes.
module cmp_result_debouncer
    import cmp_result_debouncer_pkg::*;
#(
    parameter int unsigned Debounce = 4,
    parameter int unsigned CntW     = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    input  logic            a_greater_i,
    input  logic            a_equal_i,
    input  logic            a_less_i,
    input  logic            clr_counts_i,
    output logic [1:0]      state_o,
    output logic            state_valid_o,
    output logic            change_pulse_o,
    output logic            illegal_o,
    output logic [CntW-1:0] gt_count_o,
    output logic [CntW-1:0] eq_count_o,
    output logic [CntW-1:0] lt_count_o
);

    localparam int unsigned     RunW   = $clog2(Debounce + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(Debounce);

    cmp_state_e      sample_cls;
    logic            sample_legal;
    cmp_state_e      state_d, state_q, cand_d, cand_q;
    logic [RunW-1:0] run_d, run_q;
    logic            valid_d, valid_q, pulse_d, pulse_q, illegal_d, illegal_q;

    always_comb begin
        sample_cls   = flags_to_state(a_greater_i, a_equal_i, a_less_i);
        sample_legal = in_valid_i && (sample_cls != StUnknown);
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        cand_d    = cand_q;
        run_d     = run_q;
        pulse_d   = 1'b0;
        illegal_d = 1'b0;
        if (in_valid_i) begin
            if (!sample_legal) begin
                illegal_d = 1'b1;
                cand_d    = StUnknown;
                run_d     = '0;
            end else begin
                if (sample_cls == cand_q) begin
                    run_d = (run_q == RunMax) ? RunMax : run_q + RunW'(1);
                end else begin
                    cand_d = sample_cls;
                    run_d  = RunW'(1);
                end
                // Run saturates, so a steady stream commits at most once.
                if ((run_d == RunMax) && (sample_cls != state_q)) begin
                    state_d = sample_cls;
                    valid_d = 1'b1;
                    pulse_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StUnknown;
            cand_q    <= StUnknown;
            run_q     <= '0;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            valid_q   <= valid_d;
            pulse_q   <= pulse_d;
            illegal_q <= illegal_d;
        end
    end

    assign state_o        = state_q;
    assign state_valid_o  = valid_q;
    assign change_pulse_o = pulse_q;
    assign illegal_o      = illegal_q;

    cmp_result_debouncer_sat_counter #(
        .Width (CntW)
    ) u_gt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (sample_legal && (sample_cls == StGreater)),
        .clr_i   (clr_counts_i),
        .count_o (gt_count_o)
    );

    cmp_result_debouncer_sat_counter #(
        .Width (CntW)
    ) u_eq_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (sample_legal && (sample_cls == StEqual)),
        .clr_i   (clr_counts_i),
        .count_o (eq_count_o)
    );

    cmp_result_debouncer_sat_counter #(
        .Width (CntW)
    ) u_lt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (sample_legal && (sample_cls == StLess)),
        .clr_i   (clr_counts_i),
        .count_o (lt_count_o)
    );

endmodule

// File: tb/tb_cmp_result_debouncer.sv
// Scoreboard bench: a Debounce=4 instance with directed vectors and a Debounce=1 instance fed by a comparator model.
module tb_cmp_result_debouncer;

    typedef struct packed {
        logic [7:0] tag;
        logic       chk_cnt;
        logic [1:0] st;
        logic       v;
        logic       p;
        logic       i;
        logic [7:0] gt;
        logic [7:0] eq;
        logic [7:0] lt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, g0, e0, l0, clr0;
    logic [1:0] st0;
    logic       sv0, cp0, il0;
    logic [7:0] gt0, eq0, lt0;
    logic       v1, g1, e1, l1;
    logic [1:0] st1;
    logic       sv1, cp1, il1;
    logic [7:0] gt1, eq1, lt1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] tag = 8'd0;

    always #5 clk = ~clk;

    cmp_result_debouncer #(.Debounce(4), .CntW(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .a_greater_i(g0), .a_equal_i(e0),
        .a_less_i(l0), .clr_counts_i(clr0), .state_o(st0), .state_valid_o(sv0),
        .change_pulse_o(cp0), .illegal_o(il0), .gt_count_o(gt0), .eq_count_o(eq0),
        .lt_count_o(lt0)
    );

    cmp_result_debouncer #(.Debounce(1), .CntW(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .a_greater_i(g1), .a_equal_i(e1),
        .a_less_i(l1), .clr_counts_i(1'b0), .state_o(st1), .state_valid_o(sv1),
        .change_pulse_o(cp1), .illegal_o(il1), .gt_count_o(gt1), .eq_count_o(eq1),
        .lt_count_o(lt1)
    );

    // Monitor: reset-level checks while rst is high, otherwise one scoreboard pop per edge.
    always @(posedge clk or posedge rst) begin
        #1;
        if (rst) begin
            n_vec++;
            if ({st0, sv0, cp0, il0, gt0, eq0, lt0, st1, sv1, cp1, il1} !== '0) begin
                n_err++;
                $display("FAIL reset t%0d: got st=%b v=%b p=%b i=%b gt=%0d eq=%0d lt=%0d, want all 0",
                         tag, st0, sv0, cp0, il0, gt0, eq0, lt0);
            end
        end else begin
            if (q0.size() != 0) begin
                m_e = q0.pop_front();
                n_vec++;
                if ({st0, sv0, cp0, il0} !== {m_e.st, m_e.v, m_e.p, m_e.i} ||
                    (m_e.chk_cnt && ({gt0, eq0, lt0} !== {m_e.gt, m_e.eq, m_e.lt}))) begin
                    n_err++;
                    $display("FAIL dut0 t%0d: got st=%b v=%b p=%b i=%b gt=%0d eq=%0d lt=%0d, want st=%b v=%b p=%b i=%b gt=%0d eq=%0d lt=%0d",
                             m_e.tag, st0, sv0, cp0, il0, gt0, eq0, lt0,
                             m_e.st, m_e.v, m_e.p, m_e.i, m_e.gt, m_e.eq, m_e.lt);
                end
            end
            if (q1.size() != 0) begin
                m_e = q1.pop_front();
                n_vec++;
                if ({st1, sv1, cp1, il1} !== {m_e.st, m_e.v, m_e.p, m_e.i}) begin
                    n_err++;
                    $display("FAIL dut1 chain: got st=%b v=%b p=%b i=%b, want st=%b v=%b p=%b i=%b",
                             st1, sv1, cp1, il1, m_e.st, m_e.v, m_e.p, m_e.i);
                end
            end
        end
    end

    // Drive one dut0 sample at a negedge and queue its expected post-edge outputs.
    task automatic step(input logic v, input logic [2:0] f, input logic clr,
                        input logic [1:0] es, input logic ev, input logic ep, input logic ei,
                        input int egt, input int eeq, input int elt);
        exp_t e;
        v0 = v;
        {g0, e0, l0} = f;
        clr0 = clr;
        e.tag = tag;
        e.chk_cnt = 1'b1;
        e.st = es; e.v = ev; e.p = ep; e.i = ei;
        e.gt = egt[7:0]; e.eq = eeq[7:0]; e.lt = elt[7:0];
        q0.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic pulse_rst();
        v0 = 1'b0; clr0 = 1'b0; {g0, e0, l0} = 3'b000;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] bad [4];
        int a, b, cls, prev;
        bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b111;
        rst = 1'b1;
        {v0, g0, e0, l0, clr0} = '0;
        {v1, g1, e1, l1} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: four GREATER samples commit on the fourth edge, then no repeat pulse.
        tag = 8'd1;
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 2, 0, 0);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 3, 0, 0);
        step(1, 3'b100, 0, 2'b11, 1, 1, 0, 4, 0, 0);
        step(0, 3'b100, 0, 2'b11, 1, 0, 0, 4, 0, 0);
        step(1, 3'b100, 0, 2'b11, 1, 0, 0, 5, 0, 0);
        step(0, 3'b000, 0, 2'b11, 1, 0, 0, 5, 0, 0);
        pulse_rst();

        // 2: G,G,G,L,G,G,G,G -- the LESS restarts the run.
        tag = 8'd2;
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 2, 0, 0);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 3, 0, 0);
        step(1, 3'b001, 0, 2'b00, 0, 0, 0, 3, 0, 1);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 4, 0, 1);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 5, 0, 1);
        step(1, 3'b100, 0, 2'b00, 0, 0, 0, 6, 0, 1);
        step(1, 3'b100, 0, 2'b11, 1, 1, 0, 7, 0, 1);
        step(0, 3'b000, 0, 2'b11, 1, 0, 0, 7, 0, 1);
        pulse_rst();

        // 3: stable EQUAL, illegal 110, 3 EQUAL, 4 LESS; then other illegal codes.
        tag = 8'd3;
        for (int k = 1; k <= 4; k++) step(1, 3'b010, 0, (k == 4) ? 2'b10 : 2'b00, k == 4, k == 4, 0, 0, k, 0);
        step(1, 3'b110, 0, 2'b10, 1, 0, 1, 0, 4, 0);
        for (int k = 5; k <= 7; k++) step(1, 3'b010, 0, 2'b10, 1, 0, 0, 0, k, 0);
        for (int k = 1; k <= 4; k++) step(1, 3'b001, 0, (k == 4) ? 2'b01 : 2'b10, 1, k == 4, 0, 0, 7, k);
        step(0, 3'b000, 0, 2'b01, 1, 0, 0, 0, 7, 4);
        for (int k = 0; k < 4; k++) step(1, bad[k], 0, 2'b01, 1, 0, 1, 0, 7, 4);
        // Illegal sample in the middle of an EQUAL run forces a full new run.
        for (int k = 8; k <= 10; k++) step(1, 3'b010, 0, 2'b01, 1, 0, 0, 0, k, 4);
        step(1, 3'b000, 0, 2'b01, 1, 0, 1, 0, 10, 4);
        for (int k = 11; k <= 14; k++) step(1, 3'b010, 0, (k == 14) ? 2'b10 : 2'b01, 1, k == 14, 0, 0, k, 4);
        step(0, 3'b100, 0, 2'b10, 1, 0, 0, 0, 14, 4);
        pulse_rst();

        // 4: 300 EQUAL samples saturate eq_count; clear beats a same-cycle increment.
        tag = 8'd4;
        for (int k = 1; k <= 300; k++)
            step(1, 3'b010, 0, (k >= 4) ? 2'b10 : 2'b00, k >= 4, k == 4, 0, 0, (k > 255) ? 255 : k, 0);
        step(1, 3'b010, 1, 2'b10, 1, 0, 0, 0, 0, 0);
        step(1, 3'b010, 0, 2'b10, 1, 0, 0, 0, 1, 0);
        step(0, 3'b000, 1, 2'b10, 1, 0, 0, 0, 0, 0);
        pulse_rst();

        // 5: reset mid-run with a committed state; a fresh 4-sample run is required.
        tag = 8'd5;
        for (int k = 1; k <= 4; k++) step(1, 3'b010, 0, (k == 4) ? 2'b10 : 2'b00, k == 4, k == 4, 0, 0, k, 0);
        step(1, 3'b100, 0, 2'b10, 1, 0, 0, 1, 4, 0);
        step(1, 3'b100, 0, 2'b10, 1, 0, 0, 2, 4, 0);
        pulse_rst();
        for (int k = 1; k <= 4; k++) step(1, 3'b100, 0, (k == 4) ? 2'b11 : 2'b00, k == 4, k == 4, 0, k, 0, 0);
        step(0, 3'b000, 0, 2'b11, 1, 0, 0, 4, 0, 0);
        pulse_rst();

        // 6: comparator model feeding the Debounce=1 instance.
        tag = 8'd6;
        prev = 0;
        for (int n = 0; n < 10000; n++) begin
            exp_t e;
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            v1 = 1'b1;
            g1 = (a > b); e1 = (a == b); l1 = (a < b);
            cls = (a > b) ? 3 : ((a == b) ? 2 : 1);
            e = '0;
            e.tag = tag;
            e.st = cls[1:0]; e.v = 1'b1; e.p = (cls != prev); e.i = 1'b0;
            q1.push_back(e);
            prev = cls;
            @(negedge clk);
        end
        v1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
